fifo_word_unpacker: RTL and testbench

Downstream drain stage for the 32-bit synchronous FIFO. It pops one word at a time through the FIFO's `cs`/`rd_enb`/`e` interface, captures the registered `data_out`, and emits the word as a stream of narrower beats on a valid/ready master port, least-significant beat first. It feeds byte-wide consumers such as a UART TX or debug port, and absorbs their backpressure so the FIFO is not popped until the current word has been fully delivered.

---
 rtl/fifo_word_unpacker.sv | 122 ++++++++++++
 tb/tb_fifo_word_unpacker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_unpacker.sv
// Pops 32-bit words from a synchronous FIFO and emits them as narrow valid/ready beats, LSB beat first.
// Latency: first beat valid 3 cycles after IDLE sees a non-empty FIFO; 2-cycle bubble between words; stalls hold beats stable.
module fifo_word_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_e,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_enb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] PREV_BEAT = BW'(BEATS - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [BW-1:0]          beat_q;
    logic                   fifo_cs_q;
    logic                   fifo_rd_enb_q;
    logic                   m_valid_q;
    logic [OUT_WIDTH-1:0]   m_data_q;
    logic                   m_last_q;
    logic                   busy_q;
    logic [CNT_WIDTH-1:0]   word_cnt_q;

    logic fetch_d;
    assign fetch_d = en && !fifo_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            beat_q        <= '0;
            fifo_cs_q     <= 1'b0;
            fifo_rd_enb_q <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            busy_q        <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_d) begin
                        state_q       <= REQ;
                        fifo_cs_q     <= 1'b1;
                        fifo_rd_enb_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                REQ: begin
                    state_q       <= CAPTURE;
                    fifo_cs_q     <= 1'b0;
                    fifo_rd_enb_q <= 1'b0;
                end
                CAPTURE: begin
                    // FIFO data_out is valid now, one cycle after the read pulse
                    state_q   <= SEND;
                    shift_q   <= fifo_data;
                    beat_q    <= '0;
                    m_data_q  <= fifo_data[OUT_WIDTH-1:0];
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b0;
                end
                SEND: begin
                    if (m_ready) begin
                        shift_q  <= shift_q >> OUT_WIDTH;
                        beat_q   <= beat_q + BW'(1);
                        m_data_q <= shift_q[2*OUT_WIDTH-1:OUT_WIDTH];
                        m_last_q <= (beat_q == PREV_BEAT);
                        if (beat_q == LAST_BEAT) begin
                            word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
                            m_valid_q  <= 1'b0;
                            m_last_q   <= 1'b0;
                            if (fetch_d) begin
                                state_q       <= REQ;
                                fifo_cs_q     <= 1'b1;
                                fifo_rd_enb_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_cs     = fifo_cs_q;
    assign fifo_rd_enb = fifo_rd_enb_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench: behavioural FIFO feeding the unpacker, plus a 2-bit-counter instance for wrap.
module tb_fifo_word_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        m_ready = 1'b1;
    logic        fifo_e;
    logic [31:0] fifo_data = '0;
    logic        fifo_cs, fifo_rd_enb, m_valid, m_last, busy;
    logic [7:0]  m_data;
    logic [15:0] word_cnt;

    logic        en2 = 1'b0;
    logic        fifo_e2;
    logic [31:0] fifo_data2;
    logic        fifo_cs2, fifo_rd_enb2, m_valid2, m_last2, busy2;
    logic [7:0]  m_data2;
    logic [1:0]  word_cnt2;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int gate_viol = 0;
    int rd2_cnt = 0;

    // FIFO model: registered data_out updated on a read with cs asserted
    logic [31:0] mem [0:15];
    logic [3:0]  wr_ptr = '0;
    logic [3:0]  rd_ptr = '0;
    assign fifo_e = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_cs && fifo_rd_enb && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
        if (fifo_rd_enb) rd_pulses <= rd_pulses + 1;
        if (fifo_rd_enb && fifo_e) gate_viol <= gate_viol + 1;
        if (fifo_cs2 && fifo_rd_enb2) rd2_cnt <= rd2_cnt + 1;
    end

    assign fifo_e2    = (rd2_cnt >= 5);
    assign fifo_data2 = 32'h0403_0201;

    always #5 clk = ~clk;

    fifo_word_unpacker dut (
        .clk(clk), .rst(rst), .en(en), .fifo_e(fifo_e), .fifo_data(fifo_data),
        .fifo_cs(fifo_cs), .fifo_rd_enb(fifo_rd_enb), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
        .word_cnt(word_cnt)
    );

    fifo_word_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .fifo_e(fifo_e2), .fifo_data(fifo_data2),
        .fifo_cs(fifo_cs2), .fifo_rd_enb(fifo_rd_enb2), .m_valid(m_valid2),
        .m_ready(1'b1), .m_data(m_data2), .m_last(m_last2), .busy(busy2),
        .word_cnt(word_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, m_data}, {24'd0, d});
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, l});
    endtask

    logic [7:0] bp_dat [7] = '{8'hD4, 8'hC3, 8'hC3, 8'hB2, 8'hB2, 8'hA1, 8'hA1};
    logic       bp_rdy [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // reset state
        #12;
        chk("rst_outs", {fifo_cs, fifo_rd_enb, m_valid, m_last, busy}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
        step();
        rst = 1'b1;
        step();
        step();

        // single word
        en = 1'b1;
        m_ready = 1'b1;
        push(32'hA1B2C3D4);
        step();
        chk("sw_req", {29'd0, fifo_cs, fifo_rd_enb, busy}, 32'd7);
        chk("sw_req_valid", {31'd0, m_valid}, 32'd0);
        step();
        chk("sw_cap", {29'd0, fifo_cs, fifo_rd_enb, m_valid}, 32'd0);
        step(); beat("sw_b0", 8'hD4, 1'b0);
        step(); beat("sw_b1", 8'hC3, 1'b0);
        step(); beat("sw_b2", 8'hB2, 1'b0);
        step(); beat("sw_b3", 8'hA1, 1'b1);
        step();
        chk("sw_idle", {30'd0, m_valid, busy}, 32'd0);
        chk("sw_cnt", {16'd0, word_cnt}, 32'd1);
        chk("sw_pulses", rd_pulses, 32'd1);

        // backpressure
        m_ready = 1'b0;
        push(32'hA1B2C3D4);
        step();
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            beat("bp_stall", 8'hD4, 1'b0);
        end
        for (int c = 0; c < 7; c++) begin
            step();
            m_ready = bp_rdy[c];
            beat("bp_seq", bp_dat[c], (c >= 5));
        end
        step();
        m_ready = 1'b1;
        chk("bp_idle", {30'd0, m_valid, busy}, 32'd0);
        chk("bp_cnt", {16'd0, word_cnt}, 32'd2);
        chk("bp_pulses", rd_pulses, 32'd2);

        // back-to-back
        push(32'h11223344);
        push(32'h55667788);
        step();
        step();
        step(); beat("bb_a0", 8'h44, 1'b0);
        step(); beat("bb_a1", 8'h33, 1'b0);
        step(); beat("bb_a2", 8'h22, 1'b0);
        step(); beat("bb_a3", 8'h11, 1'b1);
        step();
        chk("bb_bub1", {30'd0, m_valid, fifo_rd_enb}, 32'd1);
        step();
        chk("bb_bub2", {30'd0, m_valid, fifo_rd_enb}, 32'd0);
        step(); beat("bb_b0", 8'h88, 1'b0);
        step(); beat("bb_b1", 8'h77, 1'b0);
        step(); beat("bb_b2", 8'h66, 1'b0);
        step(); beat("bb_b3", 8'h55, 1'b1);
        step();
        chk("bb_cnt", {16'd0, word_cnt}, 32'd4);
        chk("bb_pulses", rd_pulses, 32'd4);

        // empty, then disabled
        for (int c = 0; c < 20; c++) begin
            step();
            chk("empty_quiet", {29'd0, fifo_rd_enb, fifo_cs, m_valid}, 32'd0);
        end
        en = 1'b0;
        push(32'hCAFEF00D);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("dis_quiet", {29'd0, fifo_rd_enb, fifo_cs, m_valid}, 32'd0);
        end
        en = 1'b1;
        step();
        chk("en_req", {30'd0, fifo_rd_enb, fifo_cs}, 32'd3);
        step();
        step(); beat("en_b0", 8'h0D, 1'b0);
        step(); beat("en_b1", 8'hF0, 1'b0);
        step(); beat("en_b2", 8'hFE, 1'b0);
        step(); beat("en_b3", 8'hCA, 1'b1);
        step();
        chk("en_cnt", {16'd0, word_cnt}, 32'd5);

        // reset mid-word
        push(32'hDEADBEEF);
        push(32'h01234567);
        step();
        step();
        step(); beat("rm_b0", 8'hEF, 1'b0);
        step(); beat("rm_b1", 8'hBE, 1'b0);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("rm_outs", {fifo_cs, fifo_rd_enb, m_valid, m_last, busy}, 32'd0);
        chk("rm_data", {24'd0, m_data}, 32'd0);
        chk("rm_cnt", {16'd0, word_cnt}, 32'd0);
        step();
        rst = 1'b1;
        chk("rm_idle", {31'd0, busy}, 32'd0);
        step();
        chk("rm_req", {31'd0, fifo_rd_enb}, 32'd1);
        step();
        step(); beat("rm_n0", 8'h67, 1'b0);
        step(); beat("rm_n1", 8'h45, 1'b0);
        step(); beat("rm_n2", 8'h23, 1'b0);
        step(); beat("rm_n3", 8'h01, 1'b1);
        step();
        chk("rm_cnt_after", {16'd0, word_cnt}, 32'd1);
        chk("total_pulses", rd_pulses, 32'd7);
        chk("read_gating", gate_viol, 32'd0);

        // counter wrap on the 2-bit instance
        en2 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 20 && !(m_valid2 && m_last2); k++) step();
            chk("wrap_last_seen", {31'd0, m_valid2 && m_last2}, 32'd1);
            chk("wrap_last_data", {24'd0, m_data2}, 32'h04);
            step();
            chk("wrap_cnt", {30'd0, word_cnt2}, {30'd0, wrap_exp[w]});
        end
        for (int c = 0; c < 5; c++) step();
        chk("wrap_idle", {31'd0, busy2}, 32'd0);
        chk("wrap_reads", rd2_cnt, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
